async_fifo_wr_arbiter: RTL and testbench
========================================

# async_fifo_wr_arbiter

Round-robin write-port arbiter sharing one `async_fifo_fwft` write port among `NUM_REQ` requesters in the write clock domain. It grants the port to one requester for a burst, forwards that requester's words to the FIFO while the FIFO is not full, and tags each word with the source index. It sits between the producer blocks and the FIFO write side, with `clk` connected to the FIFO `wr_clk`.

## Interface
- `NUM_REQ`, 4: number of requesters, 2..16.
- `DATA_WIDTH`, 8: word width, equal to the FIFO `DATA_WIDTH`.
- `MAX_BURST`, 8: maximum words per grant before forced rotation, ≥1.
- `IDLE_LIMIT`, 4: consecutive cycles a granted requester may hold `req_valid` low before losing the grant, ≥1.
- `SRC_W`, derived as max(1, clog2(`NUM_REQ`)): width of the source tag.

- `clk`  in  1  clock, the FIFO write clock.
- `rst_n`  in  1  reset, asynchronous assert, active-low.
- `req_valid`  in  NUM_REQ  per-requester word valid.
- `req_data`  in  NUM_REQ*DATA_WIDTH  per-requester word; requester i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- `req_last`  in  NUM_REQ  marks the requester's final word of a burst.
- `req_ready`  out  NUM_REQ  word accepted this cycle when high together with `req_valid`.
- `fifo_full`  in  1  FIFO `full`; the reserve-adjusted flag is used directly.
- `fifo_wr_en`  out  1  FIFO write enable.
- `fifo_wr_data`  out  DATA_WIDTH  FIFO write data.
- `fifo_wr_src`  out  SRC_W  index of the requester that owns the current word.
- `grant`  out  NUM_REQ  one-hot current owner; all zeros when idle.
- `busy`  out  1  high in the GRANT state.

## Operation
- The arbiter has two states, ARB and GRANT. Registered state: `grant`, `last_idx` (reset value NUM_REQ-1), `beat_cnt`, `idle_cnt`.
- ARB state:
  - If any `req_valid` is high, select the first set bit searching upward from `last_idx`+1, wrapping modulo NUM_REQ.
  - Register the one-hot `grant`, set `last_idx` to the selected index, clear both counters, and go to GRANT.
  - If no `req_valid` is high, stay in ARB.
- GRANT state, with granted index g:
  - `req_ready[g]` = ~`fifo_full`. All other `req_ready` bits are 0.
  - `fifo_wr_en` = `req_valid[g]` & ~`fifo_full`. This is combinational, with no registered stage.
  - `fifo_wr_data` = `req_data[g]` and `fifo_wr_src` = g.
  - A transfer is any cycle with `fifo_wr_en` high. Each transfer increments `beat_cnt`.
  - `idle_cnt` increments in each cycle where `req_valid[g]` is low, and clears in any cycle where `req_valid[g]` is high.
  - Stall: `fifo_full` high with `req_valid[g]` high is a stall, not idle. In a stall both counters hold.
  - The grant is released, and the state goes to ARB at the next edge, when any of these holds:
    - a transfer carries `req_last[g]`;
    - a transfer makes `beat_cnt` reach MAX_BURST;
    - `idle_cnt` reaches IDLE_LIMIT.
  - When several release conditions hold in the same cycle, they produce a single release.
  - `req_last` is ignored on cycles with no transfer.
- ARB state outputs: `grant`, `req_ready`, and `fifo_wr_en` are 0. `fifo_wr_data` and `fifo_wr_src` are 0.
- Counter widths: `beat_cnt` is clog2(MAX_BURST+1) bits and `idle_cnt` is clog2(IDLE_LIMIT+1) bits. Neither counter wraps, because a release always precedes overflow.
- Reset: asserting `rst_n` low at any time, including mid-burst, immediately forces:
  - state ARB;
  - `grant` = 0, `busy` = 0;
  - `fifo_wr_en` = 0, `req_ready` = 0, `fifo_wr_data` = 0, `fifo_wr_src` = 0;
  - counters = 0, `last_idx` = NUM_REQ-1.
  
  A word that was partially through a burst is not replayed. After reset, requester 0 has first priority.

## Timing
- Arbitration latency: `req_valid` is sampled high at edge k in ARB. `grant`/`busy` are high after edge k. The first FIFO write occurs at edge k+1 if `fifo_full` is low.
- Throughput within a grant: one word per cycle while `req_valid[g]` is high and `fifo_full` is low.
- Rotation cost: exactly one idle (ARB) cycle between consecutive grants, even when other requesters are already waiting.
- A requester holding `req_valid` continuously with no `req_last` gets exactly MAX_BURST words per turn. With all NUM_REQ requesters active, the rotation order is strictly 0,1,…,NUM_REQ-1,0.
- Response to `fifo_full`: `fifo_wr_en` and `req_ready` fall in the same cycle `fifo_full` rises. Any overshoot protection comes from the FIFO RESERVE setting.

## Test plan
- Reset: hold `rst_n` low for 5 cycles with all `req_valid` high. Required: all outputs 0 during reset. After release, the first grant is `grant`=4'b0001 one edge later.
- Single burst:
  - Stimulus: requester 2 presents words 0x11, 0x22, 0x33, with `req_last` on 0x33; `fifo_full`=0.
  - Required: `fifo_wr_en` high for 3 consecutive cycles with `fifo_wr_src`=2 and data in order. After the last word, `grant`=0 for one cycle.
- Full fairness:
  - Stimulus: all 4 requesters keep `req_valid` high with no `req_last`; MAX_BURST=8.
  - Required: grants run 0,1,2,3,0. Each grant carries exactly 8 writes, with one bubble cycle between grants, for 40 writes with no loss or reorder.
- Backpressure:
  - Stimulus: `fifo_full` is raised for 5 cycles after the 3rd word of a burst.
  - Required: zero writes and `req_ready`=0 during those 5 cycles; counters hold; the burst still totals 8 words. A reference queue checked per source matches.
- Idle release:
  - Stimulus: the granted requester drops `req_valid` for 3 cycles.
  - Required: the grant is kept and the burst resumes.
  - Stimulus: the granted requester drops `req_valid` for 4 cycles.
  - Required: the grant is released after the 4th idle cycle, and the next requester is granted one cycle later.
- Mid-burst reset:
  - Stimulus: pull `rst_n` low between edges during requester 1's burst.
  - Required: `grant` and `fifo_wr_en` fall immediately, without waiting for an edge. After release with requesters 1 and 3 valid, requester 1 is granted first, since index 0 is not requesting.

Source files
------------

// File: rtl/async_fifo_wr_arbiter_if.sv
// Write-side bus between the producer requesters, the arbiter and the
// async_fifo_fwft write port. The arbiter connects through the master
// modport; whoever drives the requesters and models the FIFO uses slave.
interface async_fifo_wr_arbiter_if #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 8
);
    localparam int SRC_W = (NUM_REQ > 2) ? $clog2(NUM_REQ) : 1;

    logic [NUM_REQ-1:0]            req_valid;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
    logic [NUM_REQ-1:0]            req_last;
    logic [NUM_REQ-1:0]            req_ready;
    logic                          fifo_full;
    logic                          fifo_wr_en;
    logic [DATA_WIDTH-1:0]         fifo_wr_data;
    logic [SRC_W-1:0]              fifo_wr_src;
    logic [NUM_REQ-1:0]            grant;
    logic                          busy;

    modport master (
        input  req_valid, req_data, req_last, fifo_full,
        output req_ready, fifo_wr_en, fifo_wr_data, fifo_wr_src, grant, busy
    );

    modport slave (
        output req_valid, req_data, req_last, fifo_full,
        input  req_ready, fifo_wr_en, fifo_wr_data, fifo_wr_src, grant, busy
    );
endinterface

// File: rtl/async_fifo_wr_arbiter.sv
// Round-robin arbiter that shares one FIFO write port among NUM_REQ
// requesters. A requester owns the port for a burst that ends on its last
// word, after MAX_BURST words, or after IDLE_LIMIT consecutive idle cycles.
// The FIFO-facing write path is purely combinational so fifo_full throttles
// the same cycle it rises; only grant ownership and counters are registered.
module async_fifo_wr_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 8,
    parameter int MAX_BURST  = 8,
    parameter int IDLE_LIMIT = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    async_fifo_wr_arbiter_if.master bus
);
    localparam int SRC_W  = (NUM_REQ > 2) ? $clog2(NUM_REQ) : 1;
    localparam int BEAT_W = $clog2(MAX_BURST + 1);
    localparam int IDLE_W = $clog2(IDLE_LIMIT + 1);

    localparam logic [0:0] ST_ARB   = 1'b0;
    localparam logic [0:0] ST_GRANT = 1'b1;

    localparam logic [BEAT_W-1:0]  BEAT_LAST = BEAT_W'(MAX_BURST - 1);
    localparam logic [IDLE_W-1:0]  IDLE_LAST = IDLE_W'(IDLE_LIMIT - 1);
    localparam logic [SRC_W-1:0]   IDX_TOP   = SRC_W'(NUM_REQ - 1);
    localparam logic [NUM_REQ-1:0] ONE_HOT0  = NUM_REQ'(1);

    logic [0:0]            state;
    logic [NUM_REQ-1:0]    grant_q;
    logic [SRC_W-1:0]      last_idx;
    logic [BEAT_W-1:0]     beat_cnt;
    logic [IDLE_W-1:0]     idle_cnt;

    logic [DATA_WIDTH-1:0] data_arr [NUM_REQ];

    logic                  sel_found;
    logic [SRC_W-1:0]      sel_idx;
    logic [SRC_W-1:0]      cand;

    logic                  in_grant;
    logic                  valid_g;
    logic                  last_g;
    logic                  xfer;
    logic                  idle_cyc;
    logic                  release_now;

    logic [NUM_REQ-1:0]    req_ready_c;
    logic                  wr_en_c;
    logic [DATA_WIDTH-1:0] wr_data_c;
    logic [SRC_W-1:0]      wr_src_c;

    // Unpack the flat request data bus so the owner's word is a simple index.
    for (genvar i = 0; i < NUM_REQ; i++) begin : g_split
        assign data_arr[i] = bus.req_data[i*DATA_WIDTH +: DATA_WIDTH];
    end

    // While granted, last_idx is the owner index, so it doubles as the mux select.
    assign in_grant    = (state == ST_GRANT);
    assign valid_g     = bus.req_valid[last_idx];
    assign last_g      = bus.req_last[last_idx];
    assign xfer        = in_grant & valid_g & ~bus.fifo_full;
    assign idle_cyc    = in_grant & ~valid_g;
    assign release_now = (xfer & (last_g | (beat_cnt == BEAT_LAST)))
                       | (idle_cyc & (idle_cnt == IDLE_LAST));

    // Round-robin pick: first valid requester found walking upward from last_idx+1.
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        cand      = last_idx;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = (cand == IDX_TOP) ? '0 : cand + 1'b1;
            if (!sel_found && bus.req_valid[cand]) begin
                sel_found = 1'b1;
                sel_idx   = cand;
            end
        end
    end

    // Write-port steering; everything is zero unless a requester owns the port.
    always_comb begin
        req_ready_c = '0;
        wr_en_c     = 1'b0;
        wr_data_c   = '0;
        wr_src_c    = '0;
        if (in_grant) begin
            req_ready_c[last_idx] = ~bus.fifo_full;
            wr_en_c               = xfer;
            wr_data_c             = data_arr[last_idx];
            wr_src_c              = last_idx;
        end
    end

    assign bus.req_ready    = req_ready_c;
    assign bus.fifo_wr_en   = wr_en_c;
    assign bus.fifo_wr_data = wr_data_c;
    assign bus.fifo_wr_src  = wr_src_c;
    assign bus.grant        = grant_q;
    assign bus.busy         = in_grant;

    // Grant FSM with burst and idle counters; a stall (full while valid) holds both counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_ARB;
            grant_q  <= '0;
            last_idx <= IDX_TOP;
            beat_cnt <= '0;
            idle_cnt <= '0;
        end else begin
            case (state)
                ST_ARB: begin
                    if (sel_found) begin
                        state    <= ST_GRANT;
                        grant_q  <= ONE_HOT0 << sel_idx;
                        last_idx <= sel_idx;
                        beat_cnt <= '0;
                        idle_cnt <= '0;
                    end
                end
                ST_GRANT: begin
                    if (release_now) begin
                        state    <= ST_ARB;
                        grant_q  <= '0;
                        beat_cnt <= '0;
                        idle_cnt <= '0;
                    end else if (xfer) begin
                        beat_cnt <= beat_cnt + 1'b1;
                        idle_cnt <= '0;
                    end else if (idle_cyc) begin
                        idle_cnt <= idle_cnt + 1'b1;
                    end
                end
                default: begin
                    state   <= ST_ARB;
                    grant_q <= '0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_async_fifo_wr_arbiter.sv
// Self-checking bench for async_fifo_wr_arbiter: a fixed vector table,
// hand-written corner sequences, and a random run, all compared every cycle
// against a turn-based reference model plus per-source word ordering.
module tb_async_fifo_wr_arbiter;
    localparam int NUM_REQ    = 4;
    localparam int DATA_WIDTH = 8;
    localparam int MAX_BURST  = 8;
    localparam int IDLE_LIMIT = 4;

    typedef struct {
        logic [3:0]  valid;
        logic [3:0]  last;
        logic [31:0] data;
        logic        full;
        logic [3:0]  x_grant;
        logic        x_busy;
        logic        x_wr_en;
        logic [7:0]  x_data;
        logic [1:0]  x_src;
        logic [3:0]  x_ready;
    } vec_t;

    logic clk;
    logic rst_n;

    async_fifo_wr_arbiter_if #(.NUM_REQ(NUM_REQ), .DATA_WIDTH(DATA_WIDTH)) bus ();

    async_fifo_wr_arbiter #(
        .NUM_REQ   (NUM_REQ),
        .DATA_WIDTH(DATA_WIDTH),
        .MAX_BURST (MAX_BURST),
        .IDLE_LIMIT(IDLE_LIMIT)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: who owns the port, whose turn was last, words and idle cycles this turn.
    int m_owner;
    int m_last;
    int m_beats;
    int m_idle;

    logic [3:0] e_grant;
    logic       e_busy;
    logic       e_wr_en;
    logic [7:0] e_data;
    logic [1:0] e_src;
    logic [3:0] e_ready;

    logic [3:0] s_grant;
    logic       s_busy;
    logic       s_wr_en;
    logic [7:0] s_data;
    logic [1:0] s_src;
    logic [3:0] s_ready;

    vec_t vecs [9];
    vec_t cur_row;
    int   cur_idx;
    bit   row_active  = 0;
    bit   producer_on = 1;

    int seq     [NUM_REQ];
    int exp_seq [NUM_REQ];
    int wr_count;
    int src_log [$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: actual=0x%0h required=0x%0h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic [3:0] valid, input logic [3:0] last, input logic full);
        bus.req_valid = valid;
        bus.req_last  = last;
        bus.fifo_full = full;
    endtask

    function automatic void modelOutputs();
        e_grant = '0;
        e_busy  = 1'b0;
        e_wr_en = 1'b0;
        e_data  = '0;
        e_src   = '0;
        e_ready = '0;
        if (rst_n && m_owner >= 0) begin
            e_grant = 4'b0001 << m_owner;
            e_busy  = 1'b1;
            e_ready = bus.fifo_full ? 4'b0000 : (4'b0001 << m_owner);
            e_wr_en = bus.req_valid[m_owner] && !bus.fifo_full;
            e_data  = bus.req_data[m_owner*DATA_WIDTH +: DATA_WIDTH];
            e_src   = 2'(m_owner);
        end
    endfunction

    function automatic void modelStep();
        int  c;
        bit  moved;
        bit  rel;
        if (!rst_n) begin
            m_owner = -1;
            m_last  = NUM_REQ - 1;
            m_beats = 0;
            m_idle  = 0;
            return;
        end
        if (m_owner < 0) begin
            moved = 0;
            for (int k = 1; k <= NUM_REQ; k++) begin
                c = (m_last + k) % NUM_REQ;
                if (!moved && bus.req_valid[c]) begin
                    moved   = 1;
                    m_owner = c;
                    m_last  = c;
                    m_beats = 0;
                    m_idle  = 0;
                end
            end
        end else begin
            rel = 0;
            if (bus.req_valid[m_owner] && !bus.fifo_full) begin
                m_beats++;
                m_idle = 0;
                if (bus.req_last[m_owner] || m_beats == MAX_BURST) rel = 1;
            end else if (!bus.req_valid[m_owner]) begin
                m_idle++;
                if (m_idle == IDLE_LIMIT) rel = 1;
            end
            if (rel) m_owner = -1;
        end
    endfunction

    task automatic driveProducers();
        for (int i = 0; i < NUM_REQ; i++)
            bus.req_data[i*DATA_WIDTH +: DATA_WIDTH] = 8'((i << 6) | (seq[i] & 63));
    endtask

    // One clock: compare at the falling edge, advance model and producers at the rising edge.
    task automatic runCycle();
        logic [NUM_REQ-1:0] acc;
        logic [7:0]         ex;
        acc = '0;
        if (producer_on) driveProducers();
        @(negedge clk);
        s_grant = bus.grant;
        s_busy  = bus.busy;
        s_wr_en = bus.fifo_wr_en;
        s_data  = bus.fifo_wr_data;
        s_src   = bus.fifo_wr_src;
        s_ready = bus.req_ready;
        modelOutputs();
        checkOutput("model_grant", s_grant, e_grant);
        checkOutput("model_busy",  s_busy,  e_busy);
        checkOutput("model_wr_en", s_wr_en, e_wr_en);
        checkOutput("model_data",  s_data,  e_data);
        checkOutput("model_src",   s_src,   e_src);
        checkOutput("model_ready", s_ready, e_ready);
        if (row_active) begin
            checkOutput($sformatf("vec%0d_grant", cur_idx), s_grant, cur_row.x_grant);
            checkOutput($sformatf("vec%0d_busy",  cur_idx), s_busy,  cur_row.x_busy);
            checkOutput($sformatf("vec%0d_wr_en", cur_idx), s_wr_en, cur_row.x_wr_en);
            checkOutput($sformatf("vec%0d_data",  cur_idx), s_data,  cur_row.x_data);
            checkOutput($sformatf("vec%0d_src",   cur_idx), s_src,   cur_row.x_src);
            checkOutput($sformatf("vec%0d_ready", cur_idx), s_ready, cur_row.x_ready);
        end
        if (producer_on) begin
            acc = bus.req_ready & bus.req_valid;
            if (s_wr_en === 1'b1) begin
                ex = 8'((int'(s_src) << 6) | (exp_seq[s_src] & 63));
                checkOutput("per_source_order", s_data, ex);
                exp_seq[s_src]++;
            end
        end
        if (s_wr_en === 1'b1) begin
            wr_count++;
            src_log.push_back(int'(s_src));
        end
        @(posedge clk);
        modelStep();
        for (int i = 0; i < NUM_REQ; i++)
            if (acc[i]) seq[i]++;
        #1;
    endtask

    task automatic doReset();
        rst_n = 1'b0;
        applyStimulus(4'b0000, 4'b0000, 1'b0);
        runCycle();
        runCycle();
        rst_n = 1'b1;
    endtask

    initial begin
        // Single burst from requester 2, then a stalled one-word burst from requester 0.
        vecs[0] = '{4'b0100, 4'b0000, 32'h0011_0000, 1'b0, 4'b0000, 1'b0, 1'b0, 8'h00, 2'd0, 4'b0000};
        vecs[1] = '{4'b0100, 4'b0000, 32'h0011_0000, 1'b0, 4'b0100, 1'b1, 1'b1, 8'h11, 2'd2, 4'b0100};
        vecs[2] = '{4'b0100, 4'b0000, 32'h0022_0000, 1'b0, 4'b0100, 1'b1, 1'b1, 8'h22, 2'd2, 4'b0100};
        vecs[3] = '{4'b0100, 4'b0100, 32'h0033_0000, 1'b0, 4'b0100, 1'b1, 1'b1, 8'h33, 2'd2, 4'b0100};
        vecs[4] = '{4'b0000, 4'b0000, 32'h0000_0000, 1'b0, 4'b0000, 1'b0, 1'b0, 8'h00, 2'd0, 4'b0000};
        vecs[5] = '{4'b0001, 4'b0000, 32'h0000_0044, 1'b0, 4'b0000, 1'b0, 1'b0, 8'h00, 2'd0, 4'b0000};
        vecs[6] = '{4'b0001, 4'b0000, 32'h0000_0044, 1'b1, 4'b0001, 1'b1, 1'b0, 8'h44, 2'd0, 4'b0000};
        vecs[7] = '{4'b0001, 4'b0001, 32'h0000_0044, 1'b0, 4'b0001, 1'b1, 1'b1, 8'h44, 2'd0, 4'b0001};
        vecs[8] = '{4'b0000, 4'b0000, 32'h0000_0000, 1'b0, 4'b0000, 1'b0, 1'b0, 8'h00, 2'd0, 4'b0000};

        for (int i = 0; i < NUM_REQ; i++) begin
            seq[i]     = 0;
            exp_seq[i] = 0;
        end
        m_owner  = -1;
        m_last   = NUM_REQ - 1;
        m_beats  = 0;
        m_idle   = 0;
        wr_count = 0;
        rst_n    = 1'b0;
        bus.req_data = '0;
        applyStimulus(4'b0000, 4'b0000, 1'b0);
        @(posedge clk);
        #1;

        // Reset held with every requester asking; outputs must stay quiet.
        $display("[TB] reset hold");
        applyStimulus(4'b1111, 4'b0000, 1'b0);
        for (int c = 0; c < 5; c++) begin
            runCycle();
            checkOutput("rst_grant", s_grant, 4'b0000);
            checkOutput("rst_wr_en", s_wr_en, 1'b0);
            checkOutput("rst_ready", s_ready, 4'b0000);
            checkOutput("rst_busy",  s_busy,  1'b0);
        end
        rst_n = 1'b1;
        runCycle();
        runCycle();
        checkOutput("first_grant", s_grant, 4'b0001);

        // Vector table.
        $display("[TB] vector table");
        doReset();
        producer_on = 0;
        row_active  = 1;
        for (int r = 0; r < 9; r++) begin
            cur_row = vecs[r];
            cur_idx = r;
            applyStimulus(vecs[r].valid, vecs[r].last, vecs[r].full);
            bus.req_data = vecs[r].data;
            runCycle();
        end
        row_active  = 0;
        producer_on = 1;

        // Full fairness: four always-valid requesters, no last.
        $display("[TB] fairness");
        doReset();
        applyStimulus(4'b1111, 4'b0000, 1'b0);
        wr_count = 0;
        src_log.delete();
        for (int c = 0; c < 45; c++) runCycle();
        checkOutput("fair_total", wr_count, 40);
        for (int k = 0; k < 40; k++)
            checkOutput($sformatf("fair_src%0d", k),
                        (k < src_log.size()) ? src_log[k] : -1, (k / 8) % 4);

        // Backpressure: full for 5 cycles after the third word.
        $display("[TB] backpressure");
        doReset();
        wr_count = 0;
        for (int c = 0; c < 15; c++) begin
            applyStimulus(4'b0010, 4'b0000, (c >= 4 && c <= 8));
            runCycle();
            if (c >= 4 && c <= 8) begin
                checkOutput("bp_wr_en", s_wr_en, 1'b0);
                checkOutput("bp_ready", s_ready, 4'b0000);
            end
            if (c == 14) checkOutput("bp_release", s_grant, 4'b0000);
        end
        checkOutput("bp_total", wr_count, 8);

        // Idle release: three idle cycles keep the grant, four give it up.
        $display("[TB] idle release");
        doReset();
        applyStimulus(4'b0001, 4'b0000, 1'b0);
        for (int c = 0; c < 3; c++) runCycle();
        applyStimulus(4'b0000, 4'b0000, 1'b0);
        for (int c = 0; c < 3; c++) runCycle();
        applyStimulus(4'b0001, 4'b0000, 1'b0);
        runCycle();
        checkOutput("idle3_grant",  s_grant, 4'b0001);
        checkOutput("idle3_resume", s_wr_en, 1'b1);
        applyStimulus(4'b0100, 4'b0000, 1'b0);
        for (int c = 0; c < 4; c++) runCycle();
        checkOutput("idle4_held",    s_grant, 4'b0001);
        runCycle();
        checkOutput("idle4_release", s_grant, 4'b0000);
        runCycle();
        checkOutput("idle4_next",    s_grant, 4'b0100);

        // Reset between edges in the middle of requester 1's burst.
        $display("[TB] mid-burst reset");
        doReset();
        applyStimulus(4'b0010, 4'b0000, 1'b0);
        for (int c = 0; c < 3; c++) runCycle();
        @(negedge clk);
        checkOutput("mrst_pre_wr_en", bus.fifo_wr_en, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("mrst_grant", bus.grant,      4'b0000);
        checkOutput("mrst_wr_en", bus.fifo_wr_en, 1'b0);
        checkOutput("mrst_busy",  bus.busy,       1'b0);
        @(posedge clk);
        modelStep();
        #1;
        runCycle();
        rst_n = 1'b1;
        applyStimulus(4'b1010, 4'b0000, 1'b0);
        runCycle();
        runCycle();
        checkOutput("mrst_first", s_grant, 4'b0010);

        // Random traffic against the model, with occasional reset pulses.
        $display("[TB] random");
        for (int c = 0; c < 800; c++) begin
            logic [3:0] v;
            logic [3:0] l;
            for (int i = 0; i < NUM_REQ; i++) begin
                v[i] = ($urandom_range(0, 9) < 7);
                l[i] = ($urandom_range(0, 99) < 15);
            end
            rst_n = ($urandom_range(0, 99) != 0);
            applyStimulus(v, l, ($urandom_range(0, 3) == 0));
            runCycle();
        end
        rst_n = 1'b1;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
